// File: rtl/dflop_pkg.sv
// Shared constants and the occupancy-count width helper for the elastic register pipeline.
package dflop_pkg;

  localparam int DFLOP_WIDTH = 4;
  localparam int DFLOP_DEPTH = 4;

  // Width needed to hold 0..depth, never narrower than one bit.
  function automatic int cnt_w(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/dflop_pipe_if.sv
// Handshake bundle of dflop_pipe: input side, output side and flush.
// count exists only when DFLOP_PIPE_COUNT_EN is defined.
interface dflop_pipe_if
  import dflop_pkg::*;
#(
  parameter int WIDTH = DFLOP_WIDTH,
  parameter int DEPTH = DFLOP_DEPTH
);

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
`ifdef DFLOP_PIPE_COUNT_EN
  logic [cnt_w(DEPTH)-1:0] count;
`endif

  modport slave (
    input  flush, in_valid, in_data, out_ready,
`ifdef DFLOP_PIPE_COUNT_EN
    output count,
`endif
    output in_ready, out_valid, out_data
  );

  modport master (
    output flush, in_valid, in_data, out_ready,
`ifdef DFLOP_PIPE_COUNT_EN
    input  count,
`endif
    input  in_ready, out_valid, out_data
  );

endinterface

// File: rtl/dflop_stage.sv
// One pipeline stage: {valid, data} register, loads on load, valid cleared by flush or RST.
// Data only captures real words so empty stages keep stale contents.
module dflop_stage #(
  parameter int WIDTH = 4
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           flush,
  input  logic           load,
  input  logic [WIDTH:0] d,
  output logic [WIDTH:0] q
);

  always_ff @(posedge CLK) begin
    if (RST) begin
      q <= '0;
    end else begin
      if (flush) begin
        q[WIDTH] <= 1'b0;
      end else if (load) begin
        q[WIDTH] <= d[WIDTH];
      end
      if (load && d[WIDTH]) begin
        q[WIDTH-1:0] <= d[WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/dflop_pipe.sv
// Elastic DEPTH-stage register pipeline with collapsing bubbles; DEPTH-cycle latency, full rate.
// Combinational ready chain gives in_ready = 0 only when every stage is full and out_ready = 0; DFLOP_PIPE_COUNT_EN adds count.
module dflop_pipe
  import dflop_pkg::*;
#(
  parameter int WIDTH = DFLOP_WIDTH,
  parameter int DEPTH = DFLOP_DEPTH
) (
  input  logic         CLK,
  input  logic         RST,
  dflop_pipe_if.slave  bus
);

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] data;
  } stage_t;

  stage_t [DEPTH-1:0] st;
  stage_t [DEPTH-1:0] st_in;
  logic   [DEPTH:0]   rdy;

  // A stage may load if it is empty or the stage after it is moving.
  always_comb begin
    rdy        = '0;
    rdy[DEPTH] = bus.out_ready;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      rdy[k] = ~st[k].valid | rdy[k+1];
    end
  end

  always_comb begin
    st_in    = '0;
    st_in[0] = {bus.in_valid, bus.in_data};
    for (int k = 1; k < DEPTH; k++) begin
      st_in[k] = st[k-1];
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    dflop_stage #(.WIDTH(WIDTH)) u_stage (
      .CLK   (CLK),
      .RST   (RST),
      .flush (bus.flush),
      .load  (rdy[k]),
      .d     (st_in[k]),
      .q     (st[k])
    );
  end

  assign bus.in_ready  = rdy[0];
  assign bus.out_valid = st[DEPTH-1].valid;
  assign bus.out_data  = st[DEPTH-1].data;

`ifdef DFLOP_PIPE_COUNT_EN
  localparam int CW = cnt_w(DEPTH);

  logic [CW-1:0] cnt;
  logic          acc;
  logic          dlv;

  assign acc = bus.in_valid & rdy[0];
  assign dlv = st[DEPTH-1].valid & bus.out_ready;

  always_ff @(posedge CLK) begin
    if (RST || bus.flush) begin
      cnt <= '0;
    end else if (acc && !dlv) begin
      cnt <= cnt + CW'(1);
    end else if (dlv && !acc) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign bus.count = cnt;
`endif

endmodule

// File: tb/tb_dflop_pipe.sv
// Directed bench for dflop_pipe (WIDTH=4, DEPTH=4) with a queue scoreboard and a decoupled output monitor.
module tb_dflop_pipe;
  import dflop_pkg::*;

  localparam int W = 4;
  localparam int D = 4;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  dflop_pipe_if #(.WIDTH(W), .DEPTH(D)) bus ();

  dflop_pipe #(.WIDTH(W), .DEPTH(D)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int           ncmp = 0;
  int           nfail = 0;
  logic [W-1:0] sb[$];
  logic [W-1:0] mon_exp;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_cnt(input int n);
`ifdef DFLOP_PIPE_COUNT_EN
    chk("count", 32'(bus.count), 32'(n));
`else
    if (n < 0) $display("count %0d", n);
`endif
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  // Monitor: pops and compares every delivered word; records accepted words.
  always @(negedge CLK) begin
    if (!RST && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      ncmp++;
      if (sb.size() == 0) begin
        nfail++;
        $display("FAIL out_word: got %0h, expected no word (t=%0t)", bus.out_data, $time);
      end else begin
        mon_exp = sb.pop_front();
        if (bus.out_data !== mon_exp) begin
          nfail++;
          $display("FAIL out_word: got %0h, expected %0h (t=%0t)", bus.out_data, mon_exp, $time);
        end
      end
    end
    if (RST || bus.flush) begin
      sb.delete();
    end else if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin
      sb.push_back(bus.in_data);
    end
  end

  logic [W-1:0] stream_v[4] = '{4'h1, 4'h2, 4'h3, 4'h5};
  logic [W-1:0] bubble_v[3] = '{4'h8, 4'h9, 4'h6};
  logic [W-1:0] flight_v[3] = '{4'h1, 4'h2, 4'h4};

  initial begin
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;

    // Reset and idle
    RST = 1'b1;
    repeat (2) cyc();
    RST = 1'b0;
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_data", 32'(bus.out_data), 0);
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    chk_cnt(0);
    bus.out_ready = 1'b0;
    #1;
    chk("empty_in_ready", 32'(bus.in_ready), 1);
    cyc();

    // Streaming, latency and peak occupancy
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = stream_v[i];
      cyc();
      chk("stream_latency", 32'(bus.out_valid), (i == 3) ? 1 : 0);
    end
    chk_cnt(4);
    bus.in_valid = 1'b0;
    repeat (6) cyc();
    chk("stream_drained", 32'(bus.out_valid), 0);
    chk_cnt(0);

    // Backpressure fill, then release with no gaps
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = W'(4'hA + i);
      #1;
      chk("fill_in_ready", 32'(bus.in_ready), 1);
      cyc();
    end
    bus.in_data = 4'hE;
    #1;
    chk("full_in_ready", 32'(bus.in_ready), 0);
    chk_cnt(4);
    cyc();
    bus.out_ready = 1'b1;
    #1;
    chk("full_pass_in_ready", 32'(bus.in_ready), 1);
    cyc();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("drain_no_gap", 32'(bus.out_valid), 1);
      cyc();
    end
    chk("drain_done", 32'(bus.out_valid), 0);
    chk_cnt(0);

    // Bubble collapse behind a stalled head
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 4'h7;
    cyc();
    bus.in_valid = 1'b0;
    repeat (3) cyc();
    chk("head_at_out", 32'(bus.out_valid), 1);
    chk_cnt(1);
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = bubble_v[i];
      #1;
      chk("bubble_in_ready", 32'(bus.in_ready), 1);
      cyc();
    end
    bus.in_valid = 1'b0;
    #1;
    chk("bubble_full", 32'(bus.in_ready), 0);
    chk_cnt(4);

    // Accept and deliver in the same cycle while full
    bus.in_valid  = 1'b1;
    bus.in_data   = 4'hF;
    bus.out_ready = 1'b1;
    #1;
    chk("swap_in_ready", 32'(bus.in_ready), 1);
    cyc();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    chk_cnt(4);
    chk("swap_still_full", 32'(bus.in_ready), 0);
    bus.out_ready = 1'b1;
    repeat (5) cyc();
    chk_cnt(0);

    // Flush with words in flight and a word offered in the flush cycle
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = flight_v[i];
      cyc();
    end
    chk_cnt(3);
    bus.in_data = 4'h3;
    bus.flush   = 1'b1;
    cyc();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_out_valid", 32'(bus.out_valid), 0);
    chk("flush_in_ready", 32'(bus.in_ready), 1);
    chk_cnt(0);
    bus.out_ready = 1'b1;
    repeat (6) cyc();
    chk("flush_nothing_out", 32'(bus.out_valid), 0);

    // Same with a mid-stream reset
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = flight_v[i];
      cyc();
    end
    bus.in_data = 4'h3;
    RST = 1'b1;
    cyc();
    RST = 1'b0;
    bus.in_valid = 1'b0;
    chk("mrst_out_valid", 32'(bus.out_valid), 0);
    chk("mrst_out_data", 32'(bus.out_data), 0);
    chk("mrst_in_ready", 32'(bus.in_ready), 1);
    chk_cnt(0);
    bus.out_ready = 1'b1;
    repeat (6) cyc();
    chk("mrst_nothing_out", 32'(bus.out_valid), 0);

    chk("sb_empty", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
